pulse_filter_mc: RTL and testbench

// Multi-channel successor to the single-bit shift-register pulse filter, used on
// the vibration-sensor front end. Each channel is synchronised and then

---
 rtl/pulse_filter_mc.sv | 63 ++++++
 tb/tb_pulse_filter_mc.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pulse_filter_mc.sv
// pulse_filter_mc: per-channel synchronise, counter-debounce against a live threshold, with edge strobes and glitch counters
module pulse_filter_mc #(
    parameter int                  CHANNELS      = 4,
    parameter int                  CNT_W         = 8,
    parameter int                  SYNC_STAGES   = 2,
    parameter int                  GCNT_W        = 16,
    parameter logic [CHANNELS-1:0] DEFAULT_LEVEL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [CNT_W-1:0]           thresh,
    input  logic                       glitch_clr,
    input  logic [CHANNELS-1:0]        pulse_in,
    output logic [CHANNELS-1:0]        pulse_out,
    output logic [CHANNELS-1:0]        rise,
    output logic [CHANNELS-1:0]        fall,
    output logic [CHANNELS*GCNT_W-1:0] glitch_cnt
);
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;
    logic [CNT_W-1:0]    thr_eff;
    assign s       = sync_q[SYNC_STAGES-1];
    assign thr_eff = (thresh == '0) ? CNT_W'(1) : thresh;
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= DEFAULT_LEVEL;
        end else begin
            sync_q[0] <= pulse_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CNT_W-1:0]  cnt;
        logic [CNT_W:0]    cnt_inc;
        logic [GCNT_W-1:0] gcnt;
        logic              lvl, r, f, diff, flip, glitch;
        // one extra bit keeps cnt+1 from wrapping before the threshold compare
        assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
        assign diff    = s[c] ^ lvl;
        assign flip    = en & diff & (cnt_inc >= {1'b0, thr_eff});
        assign glitch  = en & ~diff & (cnt != '0);
        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt  <= '0;
                lvl  <= DEFAULT_LEVEL[c];
                r    <= 1'b0;
                f    <= 1'b0;
                gcnt <= '0;
            end else begin
                cnt  <= (!en || !diff || flip) ? '0 : cnt_inc[CNT_W-1:0];
                lvl  <= flip ? s[c] : lvl;
                r    <= flip & s[c];
                f    <= flip & ~s[c];
                gcnt <= glitch_clr ? '0 : (glitch && gcnt != '1) ? gcnt + GCNT_W'(1) : gcnt;
            end
        end
        assign pulse_out[c]                   = lvl;
        assign rise[c]                        = r;
        assign fall[c]                        = f;
        assign glitch_cnt[c*GCNT_W +: GCNT_W] = gcnt;
    end
endmodule

// File: tb/tb_pulse_filter_mc.sv
// tb_pulse_filter_mc: directed scenarios plus random traffic against a behavioural model
module tb_pulse_filter_mc;
    localparam logic [3:0] DEF = 4'b0101;
    logic        clk = 1'b0;
    logic        rst, en, glitch_clr;
    logic [7:0]  thresh;
    logic [3:0]  pulse_in, po, ri, fa, po2, ri2, fa2;
    logic [63:0] gc;
    logic [15:0] gc2;
    int          total = 0, bad = 0;
    logic [3:0]  hist [$];
    logic [3:0]  m_out, m_rise, m_fall;
    int          m_run [4], m_g16 [4], m_g4 [4];

    pulse_filter_mc #(.CHANNELS(4), .CNT_W(8), .SYNC_STAGES(2), .GCNT_W(16), .DEFAULT_LEVEL(DEF)) u_dut (
        .clk(clk), .rst(rst), .en(en), .thresh(thresh), .glitch_clr(glitch_clr),
        .pulse_in(pulse_in), .pulse_out(po), .rise(ri), .fall(fa), .glitch_cnt(gc));
    pulse_filter_mc #(.CHANNELS(4), .CNT_W(8), .SYNC_STAGES(2), .GCNT_W(4), .DEFAULT_LEVEL(DEF)) u_sat (
        .clk(clk), .rst(rst), .en(en), .thresh(thresh), .glitch_clr(glitch_clr),
        .pulse_in(pulse_in), .pulse_out(po2), .rise(ri2), .fall(fa2), .glitch_cnt(gc2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Input seen by the debouncer is the raw input from two edges back;
    // a stable run of thr_eff mismatching samples flips the level.
    task automatic model_edge();
        logic [3:0] s;
        int thr;
        bit ev;
        if (!rst) begin
            hist = {};
            repeat (2) hist.push_back(DEF);
            m_out = DEF; m_rise = '0; m_fall = '0;
            for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_g16[i] = 0; m_g4[i] = 0; end
            return;
        end
        s = hist[0];
        hist.push_back(pulse_in);
        void'(hist.pop_front());
        thr = (thresh == 0) ? 1 : int'(thresh);
        for (int i = 0; i < 4; i++) begin
            ev = 0;
            m_rise[i] = 1'b0; m_fall[i] = 1'b0;
            if (en && s[i] != m_out[i]) begin
                if (m_run[i] + 1 >= thr) begin
                    m_out[i] = s[i]; m_rise[i] = s[i]; m_fall[i] = ~s[i]; m_run[i] = 0;
                end else m_run[i]++;
            end else begin
                ev = en && m_run[i] > 0;
                m_run[i] = 0;
            end
            if (glitch_clr) begin m_g16[i] = 0; m_g4[i] = 0; end
            else if (ev) begin
                if (m_g16[i] < 65535) m_g16[i]++;
                if (m_g4[i] < 15) m_g4[i]++;
            end
        end
    endtask

    task automatic step();
        logic [63:0] e16;
        logic [15:0] e4;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            e16[i*16 +: 16] = m_g16[i][15:0];
            e4[i*4 +: 4]    = m_g4[i][3:0];
        end
        chk("pulse_out", 64'(po), 64'(m_out));
        chk("rise", 64'(ri), 64'(m_rise));
        chk("fall", 64'(fa), 64'(m_fall));
        chk("glitch_cnt", gc, e16);
        chk("glitch_cnt_sat", 64'(gc2), 64'(e4));
    endtask

    initial begin
        int n, fi, ri_idx, low_cnt;
        logic [15:0] g1;
        rst = 1'b0; en = 1'b1; thresh = 8'd5; glitch_clr = 1'b0; pulse_in = '0;
        @(negedge clk);
        repeat (3) begin pulse_in = 4'($urandom); step(); end
        chk("reset_out", 64'(po), 64'(DEF));
        chk("reset_rise", 64'(ri | ri2), 64'(0));
        chk("reset_fall", 64'(fa | fa2), 64'(0));
        chk("reset_gcnt", gc, 64'(0));
        rst = 1'b1; pulse_in = DEF;
        repeat (3) step();
        chk("reset_hold", 64'(po), 64'(DEF));
        // clean rising step on ch1
        pulse_in[1] = 1'b1; n = 0;
        do begin step(); n++; end while (!po[1] && n <= 20);
        chk("step_latency", 64'(n), 64'(7));
        chk("step_rise", 64'(ri), 64'(4'b0010));
        chk("step_fall", 64'(fa), 64'(0));
        step();
        chk("step_rise_once", 64'(ri), 64'(0));
        // short pulse on ch3 is rejected, then repeated into saturation
        for (int k = 0; k < 21; k++) begin
            pulse_in[3] = 1'b1; repeat (3) step();
            pulse_in[3] = 1'b0; repeat (5) step();
            if (k == 0) begin
                chk("glitch_level", 64'(po[3]), 64'(0));
                chk("glitch_one", 64'(gc[63:48]), 64'(1));
            end
        end
        chk("glitch_count21", 64'(gc[63:48]), 64'(21));
        chk("glitch_sat", 64'(gc2[15:12]), 64'(15));
        // thresh 0 acts as 1: single-cycle dip on ch2 passes through
        thresh = 8'd0; pulse_in[2] = 1'b0; fi = -1; ri_idx = -1; low_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            pulse_in[2] = 1'b1;
            if (fa[2]) fi = k;
            if (ri[2]) ri_idx = k;
            if (!po[2]) low_cnt++;
        end
        chk("thr0_low_cycles", 64'(low_cnt), 64'(1));
        chk("thr0_strobe_gap", 64'(ri_idx - fi), 64'(1));
        chk("thr0_no_glitch", 64'(gc[47:32]), 64'(0));
        // live threshold drop on ch0
        thresh = 8'd10; pulse_in[0] = 1'b0;
        repeat (6) step();
        chk("live_hold", 64'(po[0]), 64'(1));
        thresh = 8'd3;
        step();
        chk("live_flip", 64'(po[0]), 64'(0));
        chk("live_fall", 64'(fa[0]), 64'(1));
        chk("live_no_glitch", 64'(gc[15:0]), 64'(0));
        // dropping en mid-count on ch1
        thresh = 8'd5; g1 = gc[31:16]; pulse_in[1] = 1'b0;
        repeat (4) step();
        en = 1'b0; step(); pulse_in[1] = 1'b1; repeat (4) step();
        en = 1'b1; repeat (4) step();
        chk("en_drop_level", 64'(po[1]), 64'(1));
        chk("en_drop_no_glitch", 64'(gc[31:16]), 64'(g1));
        // clear coinciding with a ch3 glitch
        pulse_in[3] = 1'b1; repeat (3) step();
        pulse_in[3] = 1'b0; repeat (2) step();
        glitch_clr = 1'b1; step(); glitch_clr = 1'b0;
        chk("clr_wins", 64'(gc[63:48]), 64'(0));
        repeat (4) step();
        // reset in the middle of a count
        pulse_in[0] = 1'b1; repeat (4) step();
        rst = 1'b0; step();
        chk("midrst_out", 64'(po), 64'(DEF));
        chk("midrst_strobes", 64'(ri | fa), 64'(0));
        chk("midrst_gcnt", gc, 64'(0));
        rst = 1'b1;
        // random traffic
        for (int k = 0; k < 4000; k++) begin
            pulse_in   = pulse_in ^ (4'($urandom) & 4'($urandom));
            if ($urandom_range(15) == 0) thresh = 8'($urandom_range(6));
            en         = ($urandom_range(15) != 0);
            glitch_clr = ($urandom_range(31) == 0);
            rst        = ($urandom_range(199) != 0);
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
